// File: rtl/demux4_dispatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// demux4_dispatch_ctrl_pkg
// Shared definitions for the 1:4 demux dispatch controller:
//   - FSM state encoding (state_t)
//   - destination mode constants (MODE_RR / MODE_ADDR)
//   - port count and statistics counter width
//   - port_onehot(): 2-bit port index to 4-bit one-hot valid vector
// -----------------------------------------------------------------------------
package demux4_dispatch_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,   // hold register empty
        ST_SEND = 1'b1    // word held, waiting for the selected consumer
    } state_t;

    localparam logic MODE_RR   = 1'b0;   // destination from round-robin pointer
    localparam logic MODE_ADDR = 1'b1;   // destination from in_dest

    localparam int NUM_PORTS = 4;
    localparam int CNT_W     = 8;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] port);
        port_onehot = 4'b0001 << port;
    endfunction

endpackage

// File: rtl/demux4_rr_ptr.sv
// -----------------------------------------------------------------------------
// demux4_rr_ptr
// 2-bit round-robin destination pointer. Advances by one (wrapping 3 -> 0)
// on every cycle where adv is high.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears ptr to 0
//   adv  in   advance the pointer this cycle
//   ptr  out  current round-robin port
// -----------------------------------------------------------------------------
module demux4_rr_ptr (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (adv) begin
            ptr <= ptr + 2'd1;   // natural 2-bit wrap gives 3 -> 0
        end
    end

endmodule

// File: rtl/demux4_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// demux4_dispatch_ctrl
// Sequencing controller for a 1:4 demux. Captures one producer word at a time
// into a holding register, drives the demux select and a one-hot per-port
// valid, and releases the word once the selected consumer is ready. The
// destination is either round-robin or taken from in_dest (mode=1).
//
// Optional build macro: DEMUX_DISPATCH_STATS_EN
//   adds cnt_clr (in) and cnt_flat (out, 4 x 8-bit saturating transfer
//   counters, port k at bits [8k+7:8k]).
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   dispatch enable (blocks new captures only)
//   mode       in   0 = round-robin, 1 = addressed destination
//   in_valid   in   producer has a word
//   in_data    in   producer word (DW bits)
//   in_dest    in   destination port when mode=1
//   in_ready   out  word accepted this cycle (combinational)
//   sel        out  registered demux select
//   out_data   out  registered shared data bus
//   out_valid  out  one-hot valid, bit[sel] only
//   out_ready  in   per-port consumer ready
//   cnt_clr    in   (stats build) synchronous clear of all counters
//   cnt_flat   out  (stats build) packed per-port transfer counters
// -----------------------------------------------------------------------------
module demux4_dispatch_ctrl
    import demux4_dispatch_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_dest,
    output logic          in_ready,
    output logic [1:0]    sel,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    input  logic          cnt_clr,
    output logic [31:0]   cnt_flat
`endif
);

    state_t        state, state_next;
    logic [1:0]    sel_next;
    logic [DW-1:0] data_next;
    logic [3:0]    valid_next;
    logic [1:0]    ptr;
    logic          in_xfer;
    logic          out_xfer;
    logic          ptr_adv;

    // Ready when empty, or when the held word leaves this same cycle, which
    // gives one word per cycle when consumers keep up.
    assign in_ready = !rst && en &&
                      ((state == ST_IDLE) || ((state == ST_SEND) && out_ready[sel]));
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = |(out_valid & out_ready);
    assign ptr_adv  = in_xfer && (mode == MODE_RR);

    demux4_rr_ptr u_rr_ptr (
        .clk (clk),
        .rst (rst),
        .adv (ptr_adv),
        .ptr (ptr)
    );

    // NOTE: every output of this block is given a default first, so any path
    // that does not assign it holds the register value instead of a latch.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        data_next  = out_data;
        valid_next = out_valid;
        if (in_xfer) begin
            // A capture wins over a simultaneous release: the new word simply
            // replaces the departing one and the FSM stays in SEND.
            state_next = ST_SEND;
            sel_next   = (mode == MODE_ADDR) ? in_dest : ptr;
            data_next  = in_data;
            valid_next = port_onehot(sel_next);
        end else if (out_xfer) begin
            // sel and out_data keep their last values after release.
            state_next = ST_IDLE;
            valid_next = 4'b0000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= 2'd0;
            out_data  <= '0;
            out_valid <= 4'b0000;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            out_data  <= data_next;
            out_valid <= valid_next;
        end
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_PORTS];

    // NOTE: this small register array is reset explicitly because its cleared
    // value is visible on cnt_flat; a storage RAM would be left unreset.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (out_valid[k] && out_ready[k] && (cnt[k] != '1)) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cnt_flat[k*CNT_W +: CNT_W] = cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux4_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux4_dispatch_ctrl
// Self-checking bench for demux4_dispatch_ctrl. A table of words with their
// expected destination port is driven through the input handshake; each
// captured word pushes {sel, data} onto a scoreboard queue, and a monitor pops
// and compares it when the consumer handshake completes. Hand-written
// sequences cover backpressure, enable gating, mid-operation reset and (with
// DEMUX_DISPATCH_STATS_EN) the transfer counters.
// -----------------------------------------------------------------------------
module tb_demux4_dispatch_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_ready;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
`ifdef DEMUX_DISPATCH_STATS_EN
    logic          cnt_clr;
    logic [31:0]   cnt_flat;
`endif

    always #5 clk = ~clk;

    demux4_dispatch_ctrl #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_DISPATCH_STATS_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt_flat  (cnt_flat)
`endif
    );

    typedef struct {
        logic          m;
        logic [1:0]    dest;
        logic [DW-1:0] data;
        logic [1:0]    exp_sel;
    } vec_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } exp_t;

    vec_t tbl [16];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [3:0] oh(input logic [1:0] p);
        logic [3:0] one;
        one = 4'b0001;
        oh  = one << p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present one word and hold it until captured; returns the number of
    // cycles it had to wait. Leaves in_valid high so words can go back-to-back.
    task automatic put(input logic m, input logic [1:0] d, input logic [DW-1:0] w,
                       input logic [1:0] es, output int waits);
        exp_t e;
        mode     = m;
        in_dest  = d;
        in_data  = w;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.sel  = es;
                e.data = w;
                sb.push_back(e);
                break;
            end
            waits++;
            if (waits > 50) begin
                check("capture_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer side and one-hot invariant, sampled mid-cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("onehot_inv", 32'($countones(out_valid) <= 1), 32'd1);
                if ((out_valid & out_ready) != 4'b0000) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_word", {20'd0, out_valid, sel, out_data},
                              {20'd0, oh(e.sel), e.sel, e.data});
                    end
                end
            end
        end
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        en        = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = 2'd0;
        out_ready = 4'b1111;
`ifdef DEMUX_DISPATCH_STATS_EN
        cnt_clr   = 1'b0;
`endif

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: actual timeout, required completion");
                $fatal(1, "bench timed out");
            end
        join_none

        // Round-robin A0..A7 (ports 0,1,2,3,0,1,2,3), leaving ptr at 0.
        tbl[0]  = '{1'b0, 2'd0, 8'hA0, 2'd0};
        tbl[1]  = '{1'b0, 2'd0, 8'hA1, 2'd1};
        tbl[2]  = '{1'b0, 2'd0, 8'hA2, 2'd2};
        tbl[3]  = '{1'b0, 2'd0, 8'hA3, 2'd3};
        tbl[4]  = '{1'b0, 2'd0, 8'hA4, 2'd0};
        tbl[5]  = '{1'b0, 2'd0, 8'hA5, 2'd1};
        tbl[6]  = '{1'b0, 2'd0, 8'hA6, 2'd2};
        tbl[7]  = '{1'b0, 2'd0, 8'hA7, 2'd3};
        // Addressed words; in_dest drives sel, ptr stays at 0.
        tbl[8]  = '{1'b1, 2'd3, 8'h11, 2'd3};
        tbl[9]  = '{1'b1, 2'd3, 8'h22, 2'd3};
        tbl[10] = '{1'b1, 2'd0, 8'h33, 2'd0};
        tbl[11] = '{1'b1, 2'd2, 8'h44, 2'd2};
        // Next round-robin word must go to port 0; in_dest is ignored.
        tbl[12] = '{1'b0, 2'd3, 8'h55, 2'd0};
        tbl[13] = '{1'b0, 2'd0, 8'h56, 2'd1};
        tbl[14] = '{1'b0, 2'd2, 8'h57, 2'd2};
        tbl[15] = '{1'b0, 2'd0, 8'h58, 2'd3};

        // Reset: two cycles, outputs cleared, in_ready forced low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sel",       32'(sel),       32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Table-driven stream, all consumers ready, back-to-back.
        foreach (tbl[i]) begin
            put(tbl[i].m, tbl[i].dest, tbl[i].data, tbl[i].exp_sel, w);
            check("stream_no_wait", 32'(w), 32'd0);
            check("latency_valid", 32'(out_valid), 32'(oh(tbl[i].exp_sel)));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drained_valid", 32'(out_valid), 32'd0);

        // Backpressure on port 0 for 5 cycles while the next word waits.
        out_ready = 4'b1110;
        put(1'b0, 2'd0, 8'hB0, 2'd0, w);
        in_data = 8'hB1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid",    32'(out_valid), 32'h1);
            check("bp_data",     32'(out_data),  32'hB0);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        out_ready = 4'b1111;
        put(1'b0, 2'd0, 8'hB1, 2'd1, w);
        check("bp_release_same_cycle", 32'(w), 32'd0);
        check("bp_next_valid", {20'd0, out_valid, sel, out_data}, {20'd0, 4'b0010, 2'd1, 8'hB1});
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Enable dropped while a word is held: it still completes, then stays idle.
        out_ready = 4'b0000;
        put(1'b0, 2'd0, 8'hC0, 2'd2, w);
        en        = 1'b0;
        in_data   = 8'hC1;
        out_ready = 4'b1111;
        @(negedge clk);
        check("en_send_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("en_delivered", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("en_idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("en_no_capture", 32'(out_valid), 32'd0);
        en       = 1'b1;
        in_valid = 1'b0;

        // Reset while sending on port 2 (ptr is 3 beforehand).
        out_ready = 4'b0000;
        put(1'b1, 2'd2, 8'hD0, 2'd2, w);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h4);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_state", {20'd0, out_valid, sel, out_data}, 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        rst       = 1'b0;
        out_ready = 4'b1111;
        put(1'b0, 2'd1, 8'hE0, 2'd0, w);
        check("post_rst_port0", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        @(posedge clk); #1;

`ifdef DEMUX_DISPATCH_STATS_EN
        // 300 transfers to port 1: counter saturates at 255, others stay 0.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("cnt_cleared", cnt_flat, 32'd0);
        for (int i = 0; i < 300; i++) begin
            put(1'b1, 2'd1, 8'(i), 2'd1, w);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("cnt_saturate", cnt_flat, 32'h0000_FF00);
        // Clear alone, then a transfer coinciding with cnt_clr must read 0.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        put(1'b1, 2'd1, 8'hEE, 2'd1, w);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        @(posedge clk); #1;
        cnt_clr  = 1'b0;
        check("cnt_clr_priority", cnt_flat, 32'd0);
        check("cnt_clr_xfer_done", 32'(out_valid), 32'd0);
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
